seq_mult_ctrl: RTL and testbench

- Control FSM for the shift-and-add sequential multiplier datapath.
- Datapath pieces it drives: multiplicand register M, accumulator A with carry C, and multiplier shift register Q (shift right, serial-in from A[0], serial-out Q[0]).
- Accepts a start request, issues load/add/shift strobes for N iterations, then pulses done.
- Sits between the top-level request interface and the datapath registers; contains no data bits itself.

---
 rtl/seq_mult_if.sv | 27 ++
 rtl/seq_mult_ctrl.sv | 84 ++++++++
 tb/tb_seq_mult_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_if.sv
// Request/strobe bundle between the multiply requester, the shift-and-add
// datapath and the sequencing controller.
interface seq_mult_if #(
  parameter int N = 4
);
  localparam int CW = $clog2(N);

  logic          start;
  logic          abort;
  logic          q0;
  logic          load;
  logic          add;
  logic          shiftr;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_idx;

  modport master (
    output start, abort, q0,
    input  load, add, shiftr, busy, done, bit_idx
  );

  modport slave (
    input  start, abort, q0,
    output load, add, shiftr, busy, done, bit_idx
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencer for an N-bit shift-and-add multiplier: load, then N add/shift
// iterations, then a one-cycle done pulse. Holds no data bits itself.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; counter parked at 0
// S_LOAD  | load M and Q from operands, clear {C,A}
// S_ADD   | add = q0 ({C,A} <= A + M when the multiplier bit is set)
// S_SHIFT | shift {C,A,Q} right; advance or finish the iteration count
// S_DONE  | product valid on {A,Q} for this single cycle
module seq_mult_ctrl #(
  parameter int N = 4
) (
  input  logic     clk,
  input  logic     clr,
  seq_mult_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (bus.start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        cnt_nxt   = '0;
        state_nxt = S_ADD;
      end
      S_ADD: state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = S_ADD;
        end
      end
      S_DONE: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
    // abort overrides every transition out of a busy state, including SHIFT->DONE
    if (state != S_IDLE && bus.abort) begin
      cnt_nxt   = '0;
      state_nxt = S_IDLE;
    end
  end

  assign bus.load    = (state == S_LOAD);
  assign bus.add     = (state == S_ADD) & bus.q0;
  assign bus.shiftr  = (state == S_SHIFT);
  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = (state == S_DONE);
  assign bus.bit_idx = (state == S_ADD || state == S_SHIFT) ? cnt : '0;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench: three controllers (N=4, 2, 8) each driving a small
// shift-and-add datapath model; products and strobe timing are checked.
module tb_seq_mult_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic       start_r = 1'b0;
  logic       abort_r = 1'b0;
  logic [7:0] opa = '0;
  logic [7:0] opb = '0;
  int         sel = 0;

  seq_mult_if #(.N(4)) if4 ();
  seq_mult_if #(.N(2)) if2 ();
  seq_mult_if #(.N(8)) if8 ();

  seq_mult_ctrl #(.N(4)) u4 (.clk(clk), .clr(clr), .bus(if4));
  seq_mult_ctrl #(.N(2)) u2 (.clk(clk), .clr(clr), .bus(if2));
  seq_mult_ctrl #(.N(8)) u8 (.clk(clk), .clr(clr), .bus(if8));

  assign if4.start = start_r && (sel == 0);
  assign if2.start = start_r && (sel == 1);
  assign if8.start = start_r && (sel == 2);
  assign if4.abort = abort_r;
  assign if2.abort = 1'b0;
  assign if8.abort = 1'b0;

  // datapath models
  logic [3:0] m4, a4, q4;
  logic       c4;
  logic [1:0] m2, a2, q2;
  logic       c2;
  logic [7:0] m8, a8, q8;
  logic       c8;
  assign if4.q0 = q4[0];
  assign if2.q0 = q2[0];
  assign if8.q0 = q8[0];

  always_ff @(posedge clk) begin
    if (if4.load) begin
      m4 <= opa[3:0]; q4 <= opb[3:0]; {c4, a4} <= '0;
    end else if (if4.add) {c4, a4} <= {1'b0, a4} + {1'b0, m4};
    else if (if4.shiftr) {c4, a4, q4} <= {1'b0, c4, a4, q4[3:1]};
  end

  always_ff @(posedge clk) begin
    if (if2.load) begin
      m2 <= opa[1:0]; q2 <= opb[1:0]; {c2, a2} <= '0;
    end else if (if2.add) {c2, a2} <= {1'b0, a2} + {1'b0, m2};
    else if (if2.shiftr) {c2, a2, q2} <= {1'b0, c2, a2, q2[1:1]};
  end

  always_ff @(posedge clk) begin
    if (if8.load) begin
      m8 <= opa; q8 <= opb; {c8, a8} <= '0;
    end else if (if8.add) {c8, a8} <= {1'b0, a8} + {1'b0, m8};
    else if (if8.shiftr) {c8, a8, q8} <= {1'b0, c8, a8, q8[7:1]};
  end

  logic        mon_load, mon_add, mon_shiftr, mon_busy, mon_done;
  logic [7:0]  mon_idx;
  logic [15:0] mon_prod;

  always_comb begin
    mon_load = if4.load; mon_add = if4.add; mon_shiftr = if4.shiftr;
    mon_busy = if4.busy; mon_done = if4.done;
    mon_idx  = {6'b0, if4.bit_idx};
    mon_prod = {8'b0, a4, q4};
    if (sel == 1) begin
      mon_load = if2.load; mon_add = if2.add; mon_shiftr = if2.shiftr;
      mon_busy = if2.busy; mon_done = if2.done;
      mon_idx  = {7'b0, if2.bit_idx};
      mon_prod = {12'b0, a2, q2};
    end else if (sel == 2) begin
      mon_load = if8.load; mon_add = if8.add; mon_shiftr = if8.shiftr;
      mon_busy = if8.busy; mon_done = if8.done;
      mon_idx  = {5'b0, if8.bit_idx};
      mon_prod = {a8, q8};
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {27'b0, mon_load, mon_add, mon_shiftr, mon_busy, mon_done} | {24'b0, mon_idx};
  endfunction

  // One full multiply on the selected instance with start pulsed for one cycle.
  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input int prod, input int addmask, input int n);
    int cyc, nbusy, ndone, done_at, imax, excl;
    logic [7:0]  amask, imask;
    logic [15:0] p;
    opa = a; opb = b; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    chk({tag, ".load"}, 32'(mon_load), 32'd1);
    cyc = 1; nbusy = 1; ndone = 0; done_at = 0; imax = 0; excl = 0;
    amask = '0; imask = '0; p = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (!mon_busy) break;
      nbusy++;
      if ((mon_load & mon_add) | (mon_load & mon_shiftr) | (mon_add & mon_shiftr)) excl++;
      if (int'(mon_idx) > imax) imax = int'(mon_idx);
      if (mon_shiftr) imask[mon_idx[2:0]] = 1'b1;
      if (!mon_load && !mon_shiftr && !mon_done) amask[mon_idx[2:0]] = mon_add;
      if (mon_done) begin
        ndone++; done_at = cyc; p = mon_prod;
      end
    end
    chk({tag, ".done_at"}, 32'(done_at), 32'(2 * n + 2));
    chk({tag, ".ndone"},   32'(ndone),   32'd1);
    chk({tag, ".busy"},    32'(nbusy),   32'(2 * n + 2));
    chk({tag, ".addmask"}, 32'(amask),   32'(addmask));
    chk({tag, ".idxseen"}, 32'(imask),   32'((1 << n) - 1));
    chk({tag, ".idxmax"},  32'(imax),    32'(n - 1));
    chk({tag, ".excl"},    32'(excl),    32'd0);
    chk({tag, ".prod"},    32'(p),       32'(prod));
  endtask

  initial begin
    int l1, l2, d1, d2, nl, nd, found;
    logic [15:0] p2;

    @(negedge clk);
    chk("reset.outs", outs(), 32'd0);
    clr = 1'b0;
    @(negedge clk);
    chk("idle.outs", outs(), 32'd0);

    run("m13x11", 8'd13, 8'd11, 143, 'b1011, 4);
    run("m15x0",  8'd15, 8'd0,  0,   'b0000, 4);
    run("m15x15", 8'd15, 8'd15, 225, 'b1111, 4);

    // back-to-back with start held high
    opa = 8'd13; opb = 8'd11; start_r = 1'b1;
    l1 = 0; l2 = 0; d1 = 0; d2 = 0; nl = 0; nd = 0; p2 = '0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (mon_load) begin nl++; if (nl == 1) l1 = c; else l2 = c; end
      if (mon_done) begin nd++; if (nd == 1) d1 = c; else begin d2 = c; p2 = mon_prod; end end
      if (c == 22) start_r = 1'b0;
    end
    @(negedge clk);
    chk("b2b.load1", 32'(l1), 32'd1);
    chk("b2b.load2", 32'(l2), 32'd12);
    chk("b2b.done1", 32'(d1), 32'd10);
    chk("b2b.done2", 32'(d2), 32'd21);
    chk("b2b.nload", 32'(nl), 32'd2);
    chk("b2b.ndone", 32'(nd), 32'd2);
    chk("b2b.prod",  32'(p2), 32'd143);
    chk("b2b.idle",  32'(mon_busy), 32'd0);

    // abort in SHIFT at bit_idx 2
    opa = 8'd13; opb = 8'd11; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (mon_shiftr && mon_idx == 8'd2) begin found = 1; break; end
      @(negedge clk);
    end
    chk("abort.reach", 32'(found), 32'd1);
    abort_r = 1'b1;
    @(negedge clk);
    abort_r = 1'b0;
    chk("abort.outs", outs(), 32'd0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mon_done || mon_busy) nd++;
    end
    chk("abort.quiet", 32'(nd), 32'd0);
    run("m7x9", 8'd7, 8'd9, 63, 'b1001, 4);

    // start and abort together in IDLE: start wins, abort then cancels LOAD
    start_r = 1'b1; abort_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    chk("sa.load", 32'(mon_load), 32'd1);
    @(negedge clk);
    abort_r = 1'b0;
    chk("sa.idle", outs(), 32'd0);

    // async clr in the middle of an ADD with add asserted
    opa = 8'd13; opb = 8'd11; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (mon_add && mon_idx == 8'd1) begin found = 1; break; end
      @(negedge clk);
    end
    chk("clr.reach", 32'(found), 32'd1);
    #1 clr = 1'b1;
    #1 chk("clr.outs", outs(), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("clr.after", outs(), 32'd0);
    run("m15x15b", 8'd15, 8'd15, 225, 'b1111, 4);

    sel = 1;
    @(negedge clk);
    run("n2.m3x3", 8'd3, 8'd3, 9, 'b11, 2);
    sel = 2;
    @(negedge clk);
    run("n8.m200x255", 8'd200, 8'd255, 51000, 'hFF, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
